parking_gate_ctrl: RTL and testbench
====================================

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 Parameter CAP, default 7: maximum occupancy; legal range 1..7.
REQ-002 Parameter TMO, default 100: cycles allowed in RAISE or PASS before a forced close; legal range 2..255.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset; clears all state immediately while low.
REQ-005 ent_req  in  1  level; a vehicle is waiting at the entry lane.
REQ-006 ext_req  in  1  level; a vehicle is waiting at the exit lane.
REQ-007 cnt  in  3  current lot occupancy from the occupancy counter.
REQ-008 up_lim  in  1  level; barrier fully raised.
REQ-009 dn_lim  in  1  level; barrier fully lowered.
REQ-010 pass  in  1  one-cycle pulse; the vehicle has cleared the barrier.
REQ-011 gate_up  out  1  barrier command: 1 = raise/hold up, 0 = lower.
REQ-012 ent_gnt  out  1  entry lane green light.
REQ-013 ext_gnt  out  1  exit lane green light.
REQ-014 full  out  1  combinational; equals 1 when cnt >= CAP.
REQ-015 tmo  out  1  one-cycle pulse on a forced close.

Function
REQ-016 The FSM SHALL have four states: IDLE, RAISE, PASS, LOWER; gate_up, ent_gnt, ext_gnt, tmo and state SHALL be registered.
REQ-017 Entry eligibility SHALL be ent_req & ~full; exit eligibility SHALL be ext_req, independent of full and of cnt.
REQ-018 In IDLE, with dn_lim=1 and at least one lane eligible, the FSM SHALL latch the winning lane into dir, go to RAISE, and set gate_up=1 on the next edge.
REQ-019 When both lanes are eligible, the lane not served last SHALL win; the last-served register resets to "exit", so entry wins the first tie.
REQ-020 In IDLE with dn_lim=0, no grant SHALL be issued and gate_up SHALL stay 0.
REQ-021 In RAISE, up_lim=1 SHALL move the FSM to PASS and assert the grant for dir only (ent_gnt or ext_gnt, never both) on the next edge.
REQ-022 In PASS, the grant and gate_up SHALL hold until pass=1; then the FSM SHALL go to LOWER, deassert the grant and gate_up, and update last-served to dir on the next edge.
REQ-023 The grant SHALL NOT be revoked if full becomes 1 during PASS.
REQ-024 An 8-bit timer SHALL clear on entry to RAISE and to PASS and SHALL increment each cycle in those states.
REQ-025 When the timer reaches TMO-1 without the exit condition, the FSM SHALL go to LOWER, drop the grant and gate_up, and pulse tmo for exactly one cycle.
REQ-026 On a timeout, last-served SHALL still update to dir, so a stuck lane cannot starve the other.
REQ-027 In LOWER, the FSM SHALL stay until dn_lim=1 and then return to IDLE; pass pulses and requests SHALL be ignored in LOWER.
REQ-028 From a grant decision in IDLE to gate_up=1 SHALL be exactly 1 cycle; from up_lim to grant SHALL be 1 cycle; from pass to grant drop SHALL be 1 cycle.
REQ-029 pass pulses in IDLE or RAISE SHALL be ignored.
REQ-030 A request withdrawn after the grant decision SHALL NOT abort the sequence; only pass or a timeout ends PASS.

Reset
REQ-031 While rst=0: state=IDLE, gate_up=0, ent_gnt=0, ext_gnt=0, tmo=0, timer=0, last-served=exit.
REQ-032 Reset asserted mid-sequence (e.g. in PASS) SHALL drop gate_up and grants asynchronously, before the next clock edge.
REQ-033 After rst rises, the first grant decision SHALL occur no earlier than the first rising edge with rst=1.

Verification
REQ-034 Entry sequence: cnt=3, dn_lim=1, ent_req=1 -> gate_up=1 after 1 cycle; up_lim=1 -> ent_gnt=1 after 1 cycle; pass pulse -> ent_gnt=0, gate_up=0 after 1 cycle; dn_lim=1 -> IDLE.
REQ-035 Lot full: cnt=7, CAP=7, ent_req=1, ext_req=0 -> full=1, gate_up stays 0 indefinitely; raise ext_req=1 -> exit sequence runs with ext_gnt=1.
REQ-036 Tie fairness: ent_req=ext_req=1 held, cnt=2, three full sequences -> grant order entry, exit, entry.
REQ-037 Timeout: TMO=10, enter PASS, no pass pulse -> grant and gate_up drop 10 cycles after PASS entry, tmo high for exactly 1 cycle, FSM waits in LOWER until dn_lim=1.
REQ-038 Stuck barrier: up_lim held 0 in RAISE with TMO=10 -> tmo pulse and gate_up=0 after 10 cycles, no grant ever asserted.
REQ-039 Async reset: rst=0 for 1 ns mid-PASS between clock edges -> gate_up=0 and ent_gnt=0 immediately; after release, ent_req=ext_req=1 -> entry wins the first tie.

Source files
------------

// File: rtl/parking_gate_ctrl_if.sv
// parking_gate_ctrl_if: lane, barrier-sensor and gate-command signals of the parking gate controller
interface parking_gate_ctrl_if;
  logic       ent_req;
  logic       ext_req;
  logic [2:0] cnt;
  logic       up_lim;
  logic       dn_lim;
  logic       pass;
  logic       gate_up;
  logic       ent_gnt;
  logic       ext_gnt;
  logic       full;
  logic       tmo;
  modport master (
    output ent_req, ext_req, cnt, up_lim, dn_lim, pass,
    input  gate_up, ent_gnt, ext_gnt, full, tmo
  );
  modport slave (
    input  ent_req, ext_req, cnt, up_lim, dn_lim, pass,
    output gate_up, ent_gnt, ext_gnt, full, tmo
  );
endinterface

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: single-barrier entry/exit sequencer with fair lane arbitration and a raise/pass watchdog
module parking_gate_ctrl #(
  parameter int CAP = 7,
  parameter int TMO = 100
) (
  input logic               clk,
  input logic               rst,
  parking_gate_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RAISE, PASS, LOWER} state_t;
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
  state_t     r_state, w_state_nxt;
  logic [7:0] r_timer, w_timer_nxt;
  logic       r_dir_ent, w_dir_ent_nxt;
  logic       r_last_ext, w_last_ext_nxt;
  logic       r_gate_up, w_gate_up_nxt;
  logic       r_ent_gnt, w_ent_gnt_nxt;
  logic       r_ext_gnt, w_ext_gnt_nxt;
  logic       r_tmo, w_tmo_nxt;
  logic       w_ent_el, w_ext_el, w_pick_ent, w_tmo_hit;
  assign bus.full    = bus.cnt >= 3'(CAP);
  assign bus.gate_up = r_gate_up;
  assign bus.ent_gnt = r_ent_gnt;
  assign bus.ext_gnt = r_ext_gnt;
  assign bus.tmo     = r_tmo;
  assign w_ent_el    = bus.ent_req & ~bus.full;
  assign w_ext_el    = bus.ext_req;
  assign w_pick_ent  = w_ent_el & (~w_ext_el | r_last_ext);
  assign w_tmo_hit   = r_timer == TMO_LAST;
  // next-state and next-output decision; an exit condition always beats a timeout in the same cycle
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_dir_ent_nxt  = r_dir_ent;
    w_last_ext_nxt = r_last_ext;
    w_gate_up_nxt  = r_gate_up;
    w_ent_gnt_nxt  = r_ent_gnt;
    w_ext_gnt_nxt  = r_ext_gnt;
    w_tmo_nxt      = 1'b0;
    case (r_state)
      IDLE: if (bus.dn_lim & (w_ent_el | w_ext_el)) begin
        w_state_nxt   = RAISE;
        w_dir_ent_nxt = w_pick_ent;
        w_timer_nxt   = 8'd0;
        w_gate_up_nxt = 1'b1;
      end
      RAISE: if (bus.up_lim) begin
        w_state_nxt   = PASS;
        w_timer_nxt   = 8'd0;
        w_ent_gnt_nxt = r_dir_ent;
        w_ext_gnt_nxt = ~r_dir_ent;
      end else if (w_tmo_hit) begin
        w_state_nxt    = LOWER;
        w_gate_up_nxt  = 1'b0;
        w_tmo_nxt      = 1'b1;
        w_last_ext_nxt = ~r_dir_ent;
      end else begin
        w_timer_nxt = r_timer + 8'd1;
      end
      PASS: if (bus.pass | w_tmo_hit) begin
        w_state_nxt    = LOWER;
        w_gate_up_nxt  = 1'b0;
        w_ent_gnt_nxt  = 1'b0;
        w_ext_gnt_nxt  = 1'b0;
        w_tmo_nxt      = ~bus.pass;
        w_last_ext_nxt = ~r_dir_ent;
      end else begin
        w_timer_nxt = r_timer + 8'd1;
      end
      LOWER: w_state_nxt = bus.dn_lim ? IDLE : LOWER;
      default: w_state_nxt = IDLE;
    endcase
  end
  // state and registered outputs; reset drops the barrier command and grants immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_timer    <= 8'd0;
      r_dir_ent  <= 1'b0;
      r_last_ext <= 1'b1;
      r_gate_up  <= 1'b0;
      r_ent_gnt  <= 1'b0;
      r_ext_gnt  <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_dir_ent  <= w_dir_ent_nxt;
      r_last_ext <= w_last_ext_nxt;
      r_gate_up  <= w_gate_up_nxt;
      r_ent_gnt  <= w_ent_gnt_nxt;
      r_ext_gnt  <= w_ext_gnt_nxt;
      r_tmo      <= w_tmo_nxt;
    end
  end
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: vector table, corner-case sequences and randomized run against a phase-level model
`timescale 1ns/100ps
module tb_parking_gate_ctrl;
  localparam int CAP = 7;
  localparam int TMO = 10;
  localparam int PH_IDLE = 0, PH_RAISING = 1, PH_PASSING = 2, PH_LOWERING = 3;
  typedef struct {
    logic       ent, ext;
    logic [2:0] cnt;
    logic       up, dn, ps;
    logic [4:0] exp;
  } vec_t;
  logic clk, rst;
  int   n_cmp = 0, n_bad = 0;
  int   m_ph, m_age;
  bit   m_ent, m_last_ent, m_tmo;
  vec_t tbl[$];
  parking_gate_ctrl_if bus ();
  parking_gate_ctrl #(.CAP(CAP), .TMO(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [4:0] outs();
    return {bus.gate_up, bus.ent_gnt, bus.ext_gnt, bus.tmo, bus.full};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic ent, ext, input logic [2:0] cnt, input logic up, dn, ps);
    bus.ent_req = ent; bus.ext_req = ext; bus.cnt = cnt;
    bus.up_lim = up; bus.dn_lim = dn; bus.pass = ps;
  endtask
  task automatic do_reset();
    drive(0, 0, 3'd0, 0, 0, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask
  task automatic m_reset();
    m_ph = PH_IDLE; m_age = 0; m_ent = 0; m_last_ent = 0; m_tmo = 0;
  endtask
  // phase-level reference: a sequence walks idle -> raising -> passing -> lowering, any overstay ends it early
  task automatic m_step(input bit ent, ext, input int cnt, input bit up, dn, ps);
    bit ee, done;
    ee = ent && cnt < CAP;
    m_tmo = 0;
    if (m_ph == PH_IDLE) begin
      if (dn && (ee || ext)) begin
        m_ent = ee && (!ext || !m_last_ent);
        m_ph = PH_RAISING;
        m_age = 0;
      end
    end else if (m_ph == PH_LOWERING) begin
      if (dn) m_ph = PH_IDLE;
    end else begin
      done = (m_ph == PH_RAISING) ? up : ps;
      if (done) begin
        if (m_ph == PH_PASSING) m_last_ent = m_ent;
        m_ph = m_ph + 1;
        m_age = 0;
      end else begin
        m_age = m_age + 1;
        if (m_age == TMO) begin
          m_ph = PH_LOWERING;
          m_tmo = 1;
          m_last_ent = m_ent;
        end
      end
    end
  endtask
  function automatic logic [4:0] m_outs(input int cnt);
    return {m_ph == PH_RAISING || m_ph == PH_PASSING, m_ph == PH_PASSING && m_ent,
            m_ph == PH_PASSING && !m_ent, m_tmo, cnt >= CAP};
  endfunction
  task automatic serve(output logic ge, output logic gx);
    bus.dn_lim = 1; bus.up_lim = 0; bus.pass = 0;
    tick();
    bus.dn_lim = 0; bus.up_lim = 1;
    tick();
    ge = bus.ent_gnt; gx = bus.ext_gnt;
    bus.pass = 1;
    tick();
    bus.pass = 0; bus.up_lim = 0; bus.dn_lim = 1;
    tick();
  endtask
  initial begin
    logic ge, gx;
    int drop, tmo_at, tmo_after, gate_at, any_gnt;
    rst = 1'b0;
    drive(0, 0, 3'd0, 0, 0, 0);
    tick(); tick();
    chk("reset_outputs", outs(), 5'b0);
    rst = 1'b1;
    tbl.push_back('{1, 0, 3'd3, 0, 1, 0, 5'b10000});
    tbl.push_back('{0, 0, 3'd3, 1, 0, 0, 5'b11000});
    tbl.push_back('{0, 0, 3'd7, 1, 0, 0, 5'b11001});
    tbl.push_back('{0, 0, 3'd3, 1, 0, 1, 5'b00000});
    tbl.push_back('{1, 1, 3'd3, 0, 0, 1, 5'b00000});
    tbl.push_back('{0, 0, 3'd3, 0, 1, 0, 5'b00000});
    tbl.push_back('{1, 1, 3'd2, 0, 1, 0, 5'b10000});
    tbl.push_back('{1, 1, 3'd2, 0, 0, 1, 5'b10000});
    tbl.push_back('{1, 1, 3'd2, 1, 0, 0, 5'b10100});
    tbl.push_back('{1, 1, 3'd2, 1, 0, 1, 5'b00000});
    tbl.push_back('{0, 0, 3'd2, 0, 1, 0, 5'b00000});
    tbl.push_back('{1, 0, 3'd7, 0, 1, 0, 5'b00001});
    tbl.push_back('{1, 0, 3'd7, 0, 1, 0, 5'b00001});
    tbl.push_back('{1, 0, 3'd7, 0, 0, 1, 5'b00001});
    tbl.push_back('{1, 1, 3'd7, 0, 0, 0, 5'b00001});
    tbl.push_back('{1, 1, 3'd7, 0, 1, 0, 5'b10001});
    tbl.push_back('{0, 1, 3'd7, 1, 1, 0, 5'b10101});
    tbl.push_back('{0, 1, 3'd7, 1, 1, 1, 5'b00001});
    tbl.push_back('{0, 0, 3'd7, 0, 1, 0, 5'b00001});
    foreach (tbl[i]) begin
      drive(tbl[i].ent, tbl[i].ext, tbl[i].cnt, tbl[i].up, tbl[i].dn, tbl[i].ps);
      tick();
      chk($sformatf("vec%0d {gate,eg,xg,tmo,full}", i), outs(), tbl[i].exp);
    end
    do_reset();
    drive(1, 1, 3'd2, 0, 1, 0);
    serve(ge, gx);
    chk("fair_1st", {ge, gx}, 2'b10);
    serve(ge, gx);
    chk("fair_2nd", {ge, gx}, 2'b01);
    serve(ge, gx);
    chk("fair_3rd", {ge, gx}, 2'b10);
    do_reset();
    drive(1, 0, 3'd3, 0, 1, 0);
    tick();
    drive(0, 0, 3'd3, 1, 0, 0);
    tick();
    chk("pass_tmo_grant_on", bus.ent_gnt, 1'b1);
    drop = 0; tmo_at = 0; tmo_after = -1; gate_at = 1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (drop != 0 && i == drop + 1) tmo_after = bus.tmo;
      if (drop == 0 && !bus.ent_gnt) begin
        drop = i; tmo_at = bus.tmo; gate_at = bus.gate_up;
      end
    end
    chk("pass_tmo_drop_cycle", drop, TMO);
    chk("pass_tmo_pulse", tmo_at, 1);
    chk("pass_tmo_pulse_end", tmo_after, 0);
    chk("pass_tmo_gate_down", gate_at, 0);
    drive(1, 1, 3'd3, 0, 0, 0);
    tick();
    chk("lower_waits_dn", bus.gate_up, 1'b0);
    bus.dn_lim = 1;
    tick();
    chk("lower_to_idle", bus.gate_up, 1'b0);
    tick();
    chk("after_tmo_raise", bus.gate_up, 1'b1);
    bus.up_lim = 1;
    tick();
    chk("after_tmo_exit_wins", {bus.ent_gnt, bus.ext_gnt}, 2'b01);
    do_reset();
    drive(1, 0, 3'd3, 0, 1, 0);
    tick();
    drive(0, 0, 3'd3, 0, 0, 0);
    drop = 0; tmo_at = 0; any_gnt = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (bus.ent_gnt || bus.ext_gnt) any_gnt = 1;
      if (drop == 0 && !bus.gate_up) begin
        drop = i; tmo_at = bus.tmo;
      end
    end
    chk("stuck_drop_cycle", drop, TMO);
    chk("stuck_tmo_pulse", tmo_at, 1);
    chk("stuck_no_grant", any_gnt, 0);
    do_reset();
    drive(1, 0, 3'd3, 0, 1, 0);
    tick();
    drive(1, 0, 3'd3, 1, 0, 0);
    tick();
    chk("async_pre_grant", {bus.gate_up, bus.ent_gnt}, 2'b11);
    #3 rst = 1'b0;
    #0.5;
    chk("async_drop", {bus.gate_up, bus.ent_gnt}, 2'b00);
    #0.5 rst = 1'b1;
    drive(1, 1, 3'd3, 0, 1, 0);
    tick();
    chk("async_after_raise", bus.gate_up, 1'b1);
    drive(1, 1, 3'd3, 1, 0, 0);
    tick();
    chk("async_entry_wins", {bus.ent_gnt, bus.ext_gnt}, 2'b10);
    do_reset();
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7) == 0);
      tick();
      m_step(bus.ent_req, bus.ext_req, bus.cnt, bus.up_lim, bus.dn_lim, bus.pass);
      chk($sformatf("rand%0d {gate,eg,xg,tmo,full}", i), outs(), m_outs(bus.cnt));
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        m_reset();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
